midi_out: RTL and testbench

//   MIDI transmitter: serialises bytes into a 31250-baud UART 8N1 stream on the MIDI OUT pin.

---
 rtl/midi_pkg.sv | 18 +
 rtl/midi_byte_fifo.sv | 67 ++++++
 rtl/midi_out.sv | 184 ++++++++++++++++++
 tb/tb_midi_out.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI OUT transmitter.
// Holds the default baud rate, the frame FSM states and the clocks-per-bit helper.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } midi_tx_state_t;

  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// Small synchronous byte FIFO feeding the MIDI transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module midi_byte_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/midi_out.sv
// MIDI OUT transmitter: buffers bytes in a small FIFO and sends them as 8N1 frames.
// Consecutive queued bytes are sent with no idle gap between stop and next start bit.
module midi_out
  import midi_pkg::*;
#(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] byteInput,
  input  logic       byteInputValid,
  output logic       byteInputReady,
  output logic       uartStream,
  output logic       busy,
  output logic       txDone
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int LW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("midi_out: CLOCK_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("midi_out: FIFO_DEPTH must be a power of two >= 2");
  end

  midi_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           uart_q, uart_d;
  logic           busy_q, busy_d;
  logic           txdone_q, txdone_d;

  logic [7:0]     fifo_data_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [LW-1:0]  fifo_level_s;
  logic [LW-1:0]  level_next_s;
  logic           push_s;
  logic           pop_s;
  logic           bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);
  assign push_s    = byteInputValid && !fifo_full_s;
  // A byte leaves the FIFO either from idle or exactly at the end of a stop bit.
  assign pop_s     = !fifo_empty_s && ((state_q == IDLE) || ((state_q == STOP) && bit_end_s));

  midi_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push_s),
    .push_data (byteInput),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      uart_q    <= 1'b1;
      busy_q    <= 1'b0;
      txdone_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_q    <= uart_d;
      busy_q    <= busy_d;
      txdone_q  <= txdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fifo_empty_s ? IDLE : START;
      START:   state_d = bit_end_s ? DATA : START;
      DATA:    state_d = (bit_end_s && (bit_idx_q == 3'd7)) ? STOP : DATA;
      STOP:    state_d = bit_end_s ? (fifo_empty_s ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    uart_d       = uart_q;
    txdone_d     = 1'b0;
    level_next_s = fifo_level_s;
    case (state_q)
      IDLE: begin
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
        if (pop_s) begin
          shift_d = fifo_data_s;
          uart_d  = 1'b0;
        end else begin
          uart_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
          uart_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (bit_idx_q == 3'd7) begin
            uart_d = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            uart_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        // Registered pulse lands on the final cycle of the stop bit.
        if (cnt_q == CNT_PENULT) begin
          txdone_d = 1'b1;
        end else begin
          txdone_d = 1'b0;
        end
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (pop_s) begin
            shift_d = fifo_data_s;
            uart_d  = 1'b0;
          end else begin
            uart_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
        uart_d    = 1'b1;
      end
    endcase
    if (push_s && !pop_s) begin
      level_next_s = fifo_level_s + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_next_s = fifo_level_s - LVL_ONE;
    end else begin
      level_next_s = fifo_level_s;
    end
    busy_d = (state_d != IDLE) || (level_next_s != {LW{1'b0}});
  end

  assign byteInputReady = !fifo_full_s;
  assign uartStream     = uart_q;
  assign busy           = busy_q;
  assign txDone         = txdone_q;

endmodule

// File: tb/tb_midi_out.sv
// Self-checking bench for midi_out: randomized bytes checked against an ideal 8N1 line model
// and an independent mid-bit line decoder, on a fast-baud instance and a 5-clocks-per-bit instance.
module tb_midi_out;

  localparam int A_HZ  = 500_000;
  localparam int A_CPB = 16;
  localparam int B_HZ  = 10;
  localparam int B_BD  = 2;
  localparam int B_CPB = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] a_byte, b_byte;
  logic a_valid, b_valid;
  logic a_ready, a_line, a_busy, a_done;
  logic b_ready, b_line, b_busy, b_done;

  always #5 clk = ~clk;

  midi_out #(.CLOCK_HZ(A_HZ), .BAUD(31250), .FIFO_DEPTH(4)) dut_a (
    .clock(clk), .resetN(rst_n), .byteInput(a_byte), .byteInputValid(a_valid),
    .byteInputReady(a_ready), .uartStream(a_line), .busy(a_busy), .txDone(a_done));

  midi_out #(.CLOCK_HZ(B_HZ), .BAUD(B_BD), .FIFO_DEPTH(4)) dut_b (
    .clock(clk), .resetN(rst_n), .byteInput(b_byte), .byteInputValid(b_valid),
    .byteInputReady(b_ready), .uartStream(b_line), .busy(b_busy), .txDone(b_done));

  int total = 0;
  int passed = 0;
  logic [7:0] drv_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  logic line_s[$];
  logic done_s[$];
  logic busy_s[$];
  logic ready_s[$];
  int   acc_s[$];
  int   line_err, done_err, busy_err, stop_err, done_cnt;

  // Ideal line level after edge N+j, where byte 0 was accepted at edge N and frames are contiguous.
  function automatic logic exp_line(input int j, input int cpb);
    int f, p;
    if (j < 1) return 1'b1;
    f = (j - 1) / (10 * cpb);
    p = ((j - 1) % (10 * cpb)) / cpb;
    if (f >= exp_q.size()) return 1'b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_q[f][p-1];
  endfunction

  // Drive queued bytes with valid/ready and record outputs after every edge.
  task automatic run(input int n, input bit sel);
    logic acc;
    line_s.delete(); done_s.delete(); busy_s.delete(); ready_s.delete(); acc_s.delete();
    for (int j = 0; j < n; j++) begin
      a_valid = 1'b0;
      b_valid = 1'b0;
      if (drv_q.size() > 0) begin
        if (sel) begin b_valid = 1'b1; b_byte = drv_q[0]; end
        else     begin a_valid = 1'b1; a_byte = drv_q[0]; end
      end
      acc = sel ? (b_valid && b_ready) : (a_valid && a_ready);
      @(posedge clk); #1;
      if (acc) begin
        void'(drv_q.pop_front());
        acc_s.push_back(j);
      end
      line_s.push_back(sel ? b_line : a_line);
      done_s.push_back(sel ? b_done : a_done);
      busy_s.push_back(sel ? b_busy : a_busy);
      ready_s.push_back(sel ? b_ready : a_ready);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_byte  = 8'hxx;
    b_byte  = 8'hxx;
  endtask

  task automatic count_wave(input int cpb);
    int nb;
    logic ed, eb;
    nb = exp_q.size();
    line_err = 0; done_err = 0; busy_err = 0; done_cnt = 0;
    for (int j = 0; j < line_s.size(); j++) begin
      ed = (j > 0) && (j % (10 * cpb) == 0) && (j <= nb * 10 * cpb);
      eb = (j <= nb * 10 * cpb);
      if (line_s[j] !== exp_line(j, cpb)) line_err++;
      if (done_s[j] !== ed) done_err++;
      if (busy_s[j] !== eb) busy_err++;
      if (done_s[j] === 1'b1) done_cnt++;
    end
  endtask

  // Independent receiver: find start edges and sample each bit at its centre.
  task automatic decode(input int cpb);
    int j;
    logic [7:0] b;
    dec_q.delete();
    stop_err = 0;
    j = 0;
    while (j + 10 * cpb <= line_s.size()) begin
      if (line_s[j] === 1'b0) begin
        for (int i = 0; i < 8; i++) b[i] = line_s[j + cpb * (i + 1) + cpb / 2];
        if (line_s[j + cpb * 9 + cpb / 2] !== 1'b1) stop_err++;
        dec_q.push_back(b);
        j = j + cpb * 9 + cpb / 2 + 1;
      end else begin
        j++;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_line, a_ready, a_busy, a_done} !== 4'b1100)
      $display("FAIL reset_a: line/ready/busy/done=%b required 1100", {a_line, a_ready, a_busy, a_done});
    else passed++;
    total++;
    if ({b_line, b_ready, b_busy, b_done} !== 4'b1100)
      $display("FAIL reset_b: line/ready/busy/done=%b required 1100", {b_line, b_ready, b_busy, b_done});
    else passed++;
    rst_n = 1'b1;
    run(40, 1'b0);
    bad = 0;
    for (int j = 0; j < line_s.size(); j++)
      if (line_s[j] !== 1'b1 || busy_s[j] !== 1'b0 || done_s[j] !== 1'b0) bad++;
    total++;
    if (bad != 0) $display("FAIL idle_after_reset: %0d non-idle cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_single(input logic [7:0] b);
    drv_q = {b}; exp_q = {b};
    run(10 * A_CPB + 4, 1'b0);
    count_wave(A_CPB);
    total++;
    if (line_err != 0) $display("FAIL single_line %h: %0d bad cycles, required 0", b, line_err);
    else passed++;
    total++;
    if (done_s[10 * A_CPB] !== 1'b1 || done_err != 0)
      $display("FAIL single_txdone %h: pulse=%b errs=%0d, required 1 and 0", b, done_s[10 * A_CPB], done_err);
    else passed++;
    total++;
    if (busy_s[10 * A_CPB + 1] !== 1'b0 || busy_err != 0)
      $display("FAIL single_busy %h: after=%b errs=%0d, required 0 and 0", b, busy_s[10 * A_CPB + 1], busy_err);
    else passed++;
  endtask

  task automatic test_back_to_back;
    drv_q = {8'h90, 8'h3C, 8'h64}; exp_q = {8'h90, 8'h3C, 8'h64};
    run(30 * A_CPB + 4, 1'b0);
    count_wave(A_CPB);
    total++;
    if (acc_s.size() != 3 || acc_s[2] != 2)
      $display("FAIL b2b_accept: accepted %0d bytes, required 3 on consecutive edges", acc_s.size());
    else passed++;
    total++;
    if (line_err != 0) $display("FAIL b2b_line: %0d bad cycles, required 0", line_err);
    else passed++;
    total++;
    if (done_cnt != 3 || done_err != 0)
      $display("FAIL b2b_txdone: %0d pulses errs=%0d, required 3 and 0", done_cnt, done_err);
    else passed++;
    total++;
    if (busy_err != 0) $display("FAIL b2b_busy: %0d bad cycles, required 0", busy_err);
    else passed++;
  endtask

  task automatic test_fifo_full;
    int first_low;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    drv_q = exp_q;
    run(60 * A_CPB + 4, 1'b0);
    count_wave(A_CPB);
    decode(A_CPB);
    first_low = -1;
    for (int j = ready_s.size() - 1; j >= 0; j--) if (ready_s[j] === 1'b0) first_low = j;
    total++;
    if (first_low != 4) $display("FAIL full_ready: ready first low after edge %0d, required 4", first_low);
    else passed++;
    total++;
    if (acc_s.size() != 6 || acc_s[4] != 4 || acc_s[5] != 10 * A_CPB + 2)
      $display("FAIL full_accept: %0d accepted, 6th at %0d, required 6 and %0d",
               acc_s.size(), (acc_s.size() > 5) ? acc_s[5] : -1, 10 * A_CPB + 2);
    else passed++;
    total++;
    if (dec_q != exp_q || stop_err != 0)
      $display("FAIL full_decode: got %0d bytes stop_err=%0d, required %0d in order", dec_q.size(), stop_err, exp_q.size());
    else passed++;
    total++;
    if (line_err != 0) $display("FAIL full_line: %0d bad cycles, required 0", line_err);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int bad, jm;
    exp_q = {8'hA5};
    drv_q = {8'hA5, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    jm = 1 + 4 * A_CPB + A_CPB / 2;
    run(jm + 1, 1'b0);
    total++;
    if (line_s[jm] !== exp_line(jm, A_CPB) || acc_s.size() != 3)
      $display("FAIL midreset_setup: line=%b acc=%0d, required %b and 3", line_s[jm], acc_s.size(), exp_line(jm, A_CPB));
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a_line, a_busy, a_ready} !== 3'b101)
      $display("FAIL midreset_async: line/busy/ready=%b required 101", {a_line, a_busy, a_ready});
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    run(130 * A_CPB, 1'b0);
    bad = 0;
    for (int j = 0; j < line_s.size(); j++)
      if (line_s[j] !== 1'b1 || busy_s[j] !== 1'b0 || done_s[j] !== 1'b0) bad++;
    total++;
    if (bad != 0) $display("FAIL midreset_residual: %0d non-idle cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_slow_clock;
    drv_q = {8'hFF, 8'h00}; exp_q = {8'hFF, 8'h00};
    run(20 * B_CPB + 4, 1'b1);
    count_wave(B_CPB);
    decode(B_CPB);
    total++;
    if (line_err != 0) $display("FAIL cpb5_line: %0d bad cycles, required 0", line_err);
    else passed++;
    total++;
    if (dec_q != exp_q || stop_err != 0)
      $display("FAIL cpb5_decode: got %0d bytes stop_err=%0d, required FF,00", dec_q.size(), stop_err);
    else passed++;
    total++;
    if (done_cnt != 2 || done_s[50] !== 1'b1 || done_s[100] !== 1'b1)
      $display("FAIL cpb5_txdone: %0d pulses, required 2 at cycles 50 and 100", done_cnt);
    else passed++;
    total++;
    if (line_s[50] !== 1'b1 || line_s[51] !== 1'b0 || busy_err != 0)
      $display("FAIL cpb5_boundary: stop=%b start=%b busy_err=%0d, required 1 0 0", line_s[50], line_s[51], busy_err);
    else passed++;
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 7);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
      drv_q = exp_q;
      run(n * 10 * A_CPB + 4, 1'b0);
      count_wave(A_CPB);
      decode(A_CPB);
      total++;
      if (line_err != 0 || busy_err != 0)
        $display("FAIL rand%0d_wave: line_err=%0d busy_err=%0d, required 0 0", r, line_err, busy_err);
      else passed++;
      total++;
      if (done_cnt != n || done_err != 0)
        $display("FAIL rand%0d_txdone: %0d pulses errs=%0d, required %0d and 0", r, done_cnt, done_err, n);
      else passed++;
      total++;
      if (dec_q != exp_q || stop_err != 0)
        $display("FAIL rand%0d_decode: got %0d bytes stop_err=%0d, required %0d", r, dec_q.size(), stop_err, n);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h90);
    test_single(8'($urandom_range(0, 255)));
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_slow_clock();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
